neuron_weight_loader: RTL and testbench

Sequencer that programs the weight memories of a layer of NUM_NEURONS integrate-and-fire neurons from a streamed weight source. It can optionally read the weights back and check a checksum, and it then pulses the neurons' accumulator reset so the layer starts integrating from a clean state. It sits between the host/DMA weight stream and the shared mem_* weight-access ports of the neuron array, and owns those ports exclusively.

---
 rtl/snn_ctrl_pkg.sv | 17 +
 rtl/neuron_addr_counter.sv | 38 +++
 rtl/neuron_weight_loader.sv | 168 ++++++++++++++++
 tb/tb_neuron_weight_loader.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_ctrl_pkg.sv
// rtl/snn_ctrl_pkg.sv - shared types and width helper for the neuron weight loader
package snn_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      VERIFY,
      CLEAR,
      DONE
   } loader_state_t;

   // Index width that stays at least one bit wide for single-entry counts.
   function automatic int unsigned idx_width(input int unsigned count);
      return (count > 1) ? $clog2(count) : 1;
   endfunction

endpackage

// File: rtl/neuron_addr_counter.sv
// rtl/neuron_addr_counter.sv - two-level neuron/address walker with wrap and last flag
module neuron_addr_counter
   import snn_ctrl_pkg::*;
#(
   parameter int NUM_NEURONS = 4,
   parameter int NUM_INPUTS  = 4,
   parameter int ADDR_WIDTH  = 8,
   parameter int N_WIDTH     = idx_width(NUM_NEURONS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  step,
   output logic [N_WIDTH-1:0]    n,
   output logic [ADDR_WIDTH-1:0] a,
   output logic                  last
);

   localparam logic [N_WIDTH-1:0]    N_LAST = N_WIDTH'(NUM_NEURONS - 1);
   localparam logic [ADDR_WIDTH-1:0] A_LAST = ADDR_WIDTH'(NUM_INPUTS - 1);

   always_ff @(posedge clk) begin
      if (!rst || clear) begin
         n <= '0;
         a <= '0;
      end else if (step) begin
         if (a == A_LAST) begin
            a <= '0;
            n <= n + 1'b1;
         end else begin
            a <= a + 1'b1;
         end
      end
   end

   assign last = (n == N_LAST) && (a == A_LAST);

endmodule

// File: rtl/neuron_weight_loader.sv
// rtl/neuron_weight_loader.sv - streams weights into a neuron layer, optionally verifies, then clears
module neuron_weight_loader
   import snn_ctrl_pkg::*;
#(
   parameter int NUM_NEURONS       = 4,
   parameter int NUM_INPUTS        = 4,
   parameter int WEIGHT_SIZE       = 32,
   parameter int WEIGHT_ADDR_WIDTH = 8,
   parameter int CLEAR_CYCLES      = 2
) (
   input  logic                               mem_clk,
   input  logic                               rst,
   input  logic                               start,
   input  logic                               verify_en,
   input  logic                               w_valid,
   output logic                               w_ready,
   input  logic [WEIGHT_SIZE-1:0]             w_data,
   output logic [WEIGHT_ADDR_WIDTH-1:0]       mem_addr,
   output logic [WEIGHT_SIZE-1:0]             mem_din,
   output logic [NUM_NEURONS-1:0]             mem_wen,
   input  logic [NUM_NEURONS*WEIGHT_SIZE-1:0] mem_dout_bus,
   output logic                               neuron_rst,
   output logic                               busy,
   output logic                               done,
   output logic                               err
);

   localparam int NW = idx_width(NUM_NEURONS);
   localparam int CW = idx_width(CLEAR_CYCLES);

   loader_state_t                state;
   logic                         verify_l;
   logic                         rd_active;
   logic                         cap_valid;
   logic [NW-1:0]                n;
   logic [NW-1:0]                n_d;
   logic [WEIGHT_ADDR_WIDTH-1:0] a;
   logic                         last;
   logic [WEIGHT_SIZE-1:0]       load_sum;
   logic [WEIGHT_SIZE-1:0]       read_sum;
   logic [WEIGHT_SIZE-1:0]       rd_word;
   logic [WEIGHT_SIZE-1:0]       read_sum_next;
   logic [CW-1:0]                clr_cnt;
   logic                         handshake;
   logic                         ctr_clear;
   logic                         ctr_step;

   assign w_ready   = (state == LOAD);
   assign busy      = (state != IDLE);
   assign done      = (state == DONE);
   assign handshake = w_valid && w_ready;

   // The walker restarts whenever a phase finishes so VERIFY replays the LOAD order.
   assign ctr_clear = (state == IDLE) || (handshake && last) ||
                      ((state == VERIFY) && rd_active && last);
   assign ctr_step  = handshake || ((state == VERIFY) && rd_active);

   neuron_addr_counter #(
      .NUM_NEURONS (NUM_NEURONS),
      .NUM_INPUTS  (NUM_INPUTS),
      .ADDR_WIDTH  (WEIGHT_ADDR_WIDTH),
      .N_WIDTH     (NW)
   ) u_counter (
      .clk   (mem_clk),
      .rst   (rst),
      .clear (ctr_clear),
      .step  (ctr_step),
      .n     (n),
      .a     (a),
      .last  (last)
   );

   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
         if (n_d == NW'(i)) begin
            rd_word = mem_dout_bus[i*WEIGHT_SIZE +: WEIGHT_SIZE];
         end
      end
   end

   assign read_sum_next = read_sum + rd_word;

   always_ff @(posedge mem_clk) begin
      if (!rst) begin
         state      <= IDLE;
         verify_l   <= 1'b0;
         rd_active  <= 1'b0;
         cap_valid  <= 1'b0;
         n_d        <= '0;
         load_sum   <= '0;
         read_sum   <= '0;
         clr_cnt    <= '0;
         mem_addr   <= '0;
         mem_din    <= '0;
         mem_wen    <= '0;
         neuron_rst <= 1'b0;
         err        <= 1'b0;
      end else begin
         mem_wen <= '0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= LOAD;
                  verify_l <= verify_en;
                  err      <= 1'b0;
                  load_sum <= '0;
                  read_sum <= '0;
               end
            end
            LOAD: begin
               if (handshake) begin
                  mem_addr <= a;
                  mem_din  <= w_data;
                  mem_wen  <= NUM_NEURONS'(1) << n;
                  load_sum <= load_sum + w_data;
                  if (last) begin
                     if (verify_l) begin
                        state     <= VERIFY;
                        rd_active <= 1'b1;
                        cap_valid <= 1'b0;
                     end else begin
                        state      <= CLEAR;
                        neuron_rst <= 1'b1;
                        clr_cnt    <= '0;
                     end
                  end
               end
            end
            VERIFY: begin
               // Issue and capture overlap: the capture lags the issue by one edge.
               cap_valid <= rd_active;
               if (rd_active) begin
                  mem_addr <= a;
                  n_d      <= n;
                  if (last) begin
                     rd_active <= 1'b0;
                  end
               end
               if (cap_valid) begin
                  read_sum <= read_sum_next;
                  if (!rd_active) begin
                     err        <= (read_sum_next != load_sum);
                     state      <= CLEAR;
                     neuron_rst <= 1'b1;
                     clr_cnt    <= '0;
                  end
               end
            end
            CLEAR: begin
               if (clr_cnt == CW'(CLEAR_CYCLES - 1)) begin
                  neuron_rst <= 1'b0;
                  state      <= DONE;
               end else begin
                  clr_cnt <= clr_cnt + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_weight_loader.sv
// tb/tb_neuron_weight_loader.sv - self-checking bench for neuron_weight_loader
module tb_neuron_weight_loader;

   localparam int NN  = 2;
   localparam int NI  = 4;
   localparam int WS  = 32;
   localparam int AW  = 8;
   localparam int CC  = 2;
   localparam int NWD = NN * NI;

   logic              clk;
   logic              rst;
   logic              start;
   logic              verify_en;
   logic              w_valid;
   logic              w_ready;
   logic [WS-1:0]     w_data;
   logic [AW-1:0]     mem_addr;
   logic [WS-1:0]     mem_din;
   logic [NN-1:0]     mem_wen;
   logic [NN*WS-1:0]  mem_dout_bus;
   logic              neuron_rst;
   logic              busy;
   logic              done;
   logic              err;

   int checks = 0;
   int errors = 0;

   logic [WS-1:0] nmem [NN][256];
   logic [WS-1:0] wq [NWD];
   bit            fault;

   neuron_weight_loader #(
      .NUM_NEURONS       (NN),
      .NUM_INPUTS        (NI),
      .WEIGHT_SIZE       (WS),
      .WEIGHT_ADDR_WIDTH (AW),
      .CLEAR_CYCLES      (CC)
   ) dut (
      .mem_clk      (clk),
      .rst          (rst),
      .start        (start),
      .verify_en    (verify_en),
      .w_valid      (w_valid),
      .w_ready      (w_ready),
      .w_data       (w_data),
      .mem_addr     (mem_addr),
      .mem_din      (mem_din),
      .mem_wen      (mem_wen),
      .mem_dout_bus (mem_dout_bus),
      .neuron_rst   (neuron_rst),
      .busy         (busy),
      .done         (done),
      .err          (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      for (int k = 0; k < NN; k++) begin
         if (mem_wen[k] === 1'b1) nmem[k][mem_addr] <= mem_din;
      end
   end

   always_comb begin
      mem_dout_bus = '0;
      for (int k = 0; k < NN; k++) begin
         if (fault && k == 0 && mem_addr == 8'd2) mem_dout_bus[k*WS +: WS] = 32'hFF;
         else mem_dout_bus[k*WS +: WS] = nmem[k][mem_addr];
      end
   end

   task automatic fill_seq();
      for (int i = 0; i < NWD; i++) wq[i] = WS'(i + 1);
   endtask

   task automatic fill_rand();
      for (int i = 0; i < NWD; i++) wq[i] = $urandom;
   endtask

   // mode: 0 valid held high, 1 valid every other cycle, 2 random valid
   task automatic run_load(input bit v, input int mode, input bit flt, input bit noise, input bit lat);
      int            k;
      int            cyc;
      int            rst_cnt;
      int            done_cyc;
      int            exp_lat;
      bit            rdy;
      bit            vld;
      bit            exp_err;
      logic [WS-1:0] wsum;
      logic [WS-1:0] rsum;
      logic [NN-1:0] ew;
      fault = flt;
      wsum = '0;
      rsum = '0;
      for (int i = 0; i < NWD; i++) begin
         wsum = wsum + wq[i];
         rsum = rsum + ((flt && i == 2) ? 32'hFF : wq[i]);
      end
      exp_err = v && (rsum != wsum);
      start = 1'b1;
      verify_en = v;
      w_valid = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      verify_en = 1'($urandom);
      checks++;
      if (busy !== 1'b1 || err !== 1'b0)
         $display("FAIL start_accept: busy=%b err=%b expected busy=1 err=0", busy, err);
      if (busy !== 1'b1 || err !== 1'b0) errors++;
      k = 0; cyc = 0; rst_cnt = 0; done_cyc = -1;
      while (done_cyc < 0 && cyc < 300) begin
         case (mode)
            0: vld = 1'b1;
            1: vld = (cyc % 2 == 0);
            default: vld = 1'($urandom);
         endcase
         if (k >= NWD) vld = 1'($urandom);
         w_valid = vld;
         w_data = (k < NWD) ? wq[k] : $urandom;
         start = noise && (cyc == 2 || neuron_rst === 1'b1);
         rdy = w_ready;
         @(posedge clk); #1;
         cyc++;
         if (rdy && vld) begin
            checks++;
            if (k >= NWD) begin
               errors++;
               $display("FAIL extra_accept: word %0d accepted, expected at most %0d", k, NWD);
            end else begin
               ew = '0;
               ew[k / NI] = 1'b1;
               if (mem_wen !== ew || mem_addr !== AW'(k % NI) || mem_din !== wq[k]) begin
                  errors++;
                  $display("FAIL write_%0d: wen=%b addr=%0d din=%h expected wen=%b addr=%0d din=%h",
                           k, mem_wen, mem_addr, mem_din, ew, k % NI, wq[k]);
               end
               k++;
            end
         end else begin
            checks++;
            if (mem_wen !== '0) begin
               errors++;
               $display("FAIL idle_wen: wen=%b at cycle %0d expected 0", mem_wen, cyc);
            end
         end
         if (neuron_rst === 1'b1) rst_cnt++;
         if (done === 1'b1) done_cyc = cyc;
      end
      start = 1'b0;
      w_valid = 1'b0;
      checks++;
      if (done_cyc < 0 || k != NWD) begin
         errors++;
         $display("FAIL run_complete: done_cycle=%0d words=%0d expected done and %0d words", done_cyc, k, NWD);
      end
      checks++;
      if (rst_cnt != CC) begin
         errors++;
         $display("FAIL clear_len: neuron_rst high %0d cycles expected %0d", rst_cnt, CC);
      end
      checks++;
      if (err !== exp_err) begin
         errors++;
         $display("FAIL err_at_done: err=%b expected %b", err, exp_err);
      end
      if (lat) begin
         exp_lat = NWD + (v ? NWD + 1 : 0) + CC;
         checks++;
         if (done_cyc != exp_lat) begin
            errors++;
            $display("FAIL done_latency: %0d cycles expected %0d", done_cyc, exp_lat);
         end
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++;
         if (done !== 1'b0 || busy !== 1'b0 || err !== exp_err || mem_wen !== '0) begin
            errors++;
            $display("FAIL post_done: done=%b busy=%b err=%b wen=%b expected 0 0 %b 0",
                     done, busy, err, mem_wen, exp_err);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         checks++;
         if ({w_ready, mem_wen, mem_addr, mem_din, neuron_rst, busy, done, err} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: rdy=%b wen=%b addr=%h din=%h nrst=%b busy=%b done=%b err=%b expected all 0",
                     w_ready, mem_wen, mem_addr, mem_din, neuron_rst, busy, done, err);
         end
      end
      rst = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      fill_seq();
      run_load(1'b1, 0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_toggle_valid();
      fill_seq();
      run_load(1'b1, 1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_checksum_error();
      fill_seq();
      run_load(1'b1, 0, 1'b1, 1'b0, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL err_sticky: err=%b expected 1", err);
      end
      fill_rand();
      run_load(1'b1, 2, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_no_verify();
      fill_seq();
      run_load(1'b0, 0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_reset_mid();
      start = 1'b1;
      verify_en = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) begin
         w_valid = 1'b1;
         w_data = $urandom;
         @(posedge clk); #1;
      end
      rst = 1'b0;
      w_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({w_ready, mem_wen, mem_addr, mem_din, neuron_rst, busy, done, err} !== '0) begin
         errors++;
         $display("FAIL mid_reset: rdy=%b wen=%b addr=%h din=%h nrst=%b busy=%b done=%b err=%b expected all 0",
                  w_ready, mem_wen, mem_addr, mem_din, neuron_rst, busy, done, err);
      end
      rst = 1'b1;
      @(posedge clk); #1;
      fill_rand();
      run_load(1'b1, 0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic test_start_ignored();
      fill_rand();
      run_load(1'b1, 2, 1'b0, 1'b1, 1'b0);
   endtask

   task automatic test_random_runs();
      for (int r = 0; r < 4; r++) begin
         fill_rand();
         run_load(1'($urandom), 2, 1'($urandom), 1'b0, 1'b0);
      end
   endtask

   initial begin
      rst = 1'b0;
      start = 1'b0;
      verify_en = 1'b0;
      w_valid = 1'b0;
      w_data = '0;
      fault = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_basic();
      test_toggle_valid();
      test_checksum_error();
      test_no_verify();
      test_reset_mid();
      test_start_ignored();
      test_random_runs();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
